urv_dm_arbiter: RTL

Two-master arbiter for the uRV data-memory port. It shares one single-port data memory between the core's execute-stage load/store interface and an external master (debug/DMA). Core has fixed priority; a bounded-wait counter guarantees the external master forward progress. Sits between `urv_cpu`'s `dm_*` interface and the memory, and returns load data to whichever master issued the load.

---
 rtl/urv_dm_arbiter_pkg.sv | 15 +
 rtl/urv_dm_arbiter.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/urv_dm_arbiter_pkg.sv
// Shared owner encodings and FSM state type for the uRV data-memory arbiter.
// The state values reuse the owner codes, so the debug state output reads directly as the current owner.
package urv_dm_arbiter_pkg;

    localparam logic [1:0] ARB_OWNER_NONE = 2'd0;
    localparam logic [1:0] ARB_OWNER_CORE = 2'd1;
    localparam logic [1:0] ARB_OWNER_EXT  = 2'd2;

    typedef enum logic [1:0] {
        ST_NONE = ARB_OWNER_NONE,
        ST_CORE = ARB_OWNER_CORE,
        ST_EXT  = ARB_OWNER_EXT
    } arb_state_t;

endpackage

// File: rtl/urv_dm_arbiter.sv
// Two-master arbiter sharing one data-memory port between the core and an external master.
// The core has fixed priority; a saturating wait counter lets the external master win after G_MAX_WAIT cycles.
module urv_dm_arbiter
    import urv_dm_arbiter_pkg::*;
#(
    parameter int unsigned G_MAX_WAIT = 8
) (
    input  logic        clk_i,
    input  logic        rst_i,

    input  logic [31:0] c_addr_i,
    input  logic [31:0] c_data_s_i,
    input  logic [3:0]  c_select_i,
    input  logic        c_load_i,
    input  logic        c_store_i,
    output logic        c_ready_o,
    output logic [31:0] c_data_l_o,
    output logic        c_rvalid_o,

    input  logic [31:0] e_addr_i,
    input  logic [31:0] e_data_s_i,
    input  logic [3:0]  e_select_i,
    input  logic        e_load_i,
    input  logic        e_store_i,
    output logic        e_ready_o,
    output logic [31:0] e_data_l_o,
    output logic        e_rvalid_o,

    output logic [31:0] m_addr_o,
    output logic [31:0] m_data_s_o,
    output logic [3:0]  m_select_o,
    output logic        m_load_o,
    output logic        m_store_o,
    input  logic        m_ready_i,
    input  logic [31:0] m_data_l_i,

    output logic [1:0]  dbg_state_o,
    output logic [7:0]  dbg_wait_cnt_o
);

    localparam logic [7:0] LP_MAX_WAIT = 8'(G_MAX_WAIT);

    // Handshake: a master raises load/store and holds it with stable attributes
    // until its ready pulses; acceptance is ready && request in the same cycle.

    arb_state_t  r_state;
    arb_state_t  w_state_nxt;
    logic [7:0]  r_wait_cnt;
    logic        r_rsp_valid;
    logic [1:0]  r_rsp_owner;

    logic        w_c_req;
    logic        w_e_req;
    logic        w_sel_core;
    logic        w_sel_ext;
    logic        w_e_accept;
    logic        w_load_accept;

    assign w_c_req = c_load_i | c_store_i;
    assign w_e_req = e_load_i | e_store_i;

    always_comb begin
        w_sel_core  = 1'b0;
        w_sel_ext   = 1'b0;
        w_state_nxt = r_state;
        case (r_state)
            ST_NONE: begin
                if (w_c_req && w_e_req) begin
                    if (r_wait_cnt == LP_MAX_WAIT) w_sel_ext  = 1'b1;
                    else                           w_sel_core = 1'b1;
                end else if (w_c_req) begin
                    w_sel_core = 1'b1;
                end else if (w_e_req) begin
                    w_sel_ext = 1'b1;
                end
                if (w_sel_core && !m_ready_i)     w_state_nxt = ST_CORE;
                else if (w_sel_ext && !m_ready_i) w_state_nxt = ST_EXT;
                else                              w_state_nxt = ST_NONE;
            end
            // A dropped request while locked releases the port without a strobe.
            ST_CORE: begin
                w_sel_core  = w_c_req;
                w_state_nxt = (w_c_req && !m_ready_i) ? ST_CORE : ST_NONE;
            end
            ST_EXT: begin
                w_sel_ext   = w_e_req;
                w_state_nxt = (w_e_req && !m_ready_i) ? ST_EXT : ST_NONE;
            end
            default: begin
                w_state_nxt = ST_NONE;
            end
        endcase
        if (rst_i) begin
            w_sel_core = 1'b0;
            w_sel_ext  = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) r_state <= ST_NONE;
        else       r_state <= w_state_nxt;
    end

    // Request mux: with no grant the core attributes are presented, strobes are low.
    assign m_addr_o   = w_sel_ext ? e_addr_i   : c_addr_i;
    assign m_data_s_o = w_sel_ext ? e_data_s_i : c_data_s_i;
    assign m_select_o = w_sel_ext ? e_select_i : c_select_i;
    assign m_store_o  = (w_sel_core & c_store_i) | (w_sel_ext & e_store_i);
    assign m_load_o   = (w_sel_core & c_load_i & ~c_store_i) | (w_sel_ext & e_load_i & ~e_store_i);

    assign c_ready_o  = w_sel_core & m_ready_i;
    assign e_ready_o  = w_sel_ext & m_ready_i;

    assign w_e_accept    = e_ready_o;
    assign w_load_accept = m_load_o & m_ready_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_wait_cnt <= 8'd0;
        end else if (!w_e_req || w_e_accept) begin
            r_wait_cnt <= 8'd0;
        end else if (r_wait_cnt < LP_MAX_WAIT) begin
            r_wait_cnt <= r_wait_cnt + 8'd1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_rsp_valid <= 1'b0;
            r_rsp_owner <= ARB_OWNER_NONE;
        end else begin
            r_rsp_valid <= w_load_accept;
            r_rsp_owner <= w_sel_ext ? ARB_OWNER_EXT : ARB_OWNER_CORE;
        end
    end

    // Load data is broadcast; only the valid pulse is steered to the issuer.
    assign c_data_l_o = m_data_l_i;
    assign e_data_l_o = m_data_l_i;
    assign c_rvalid_o = r_rsp_valid & (r_rsp_owner == ARB_OWNER_CORE) & ~rst_i;
    assign e_rvalid_o = r_rsp_valid & (r_rsp_owner == ARB_OWNER_EXT) & ~rst_i;

    assign dbg_state_o    = r_state;
    assign dbg_wait_cnt_o = r_wait_cnt;

endmodule
